// File: rtl/lbm_axis_frame_streamer_if.sv
// AXI4-Stream bundle carrying one lattice cell (NUM_CH packed channels) per beat.
interface lbm_axis_frame_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 9
);
    logic                             tvalid;
    logic                             tready;
    logic [NUM_CH*DATA_WIDTH-1:0]     tdata;
    logic [NUM_CH*DATA_WIDTH/8-1:0]   tstrb;
    logic                             tlast;
    logic                             tuser;

    modport master (output tvalid, tdata, tstrb, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, tuser, output tready);
endinterface

// File: rtl/lbm_axis_frame_streamer.sv
// Streams one frame of cells from the shared-address channel RAMs onto AXI4-Stream,
// using a small prefetch FIFO sized so full-rate streaming survives backpressure.
module lbm_axis_frame_streamer #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CH        = 9,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12,
    parameter int RAM_LATENCY   = 1,
    parameter int TLAST_MODE    = 0,
    parameter int ROW_LEN       = 50
) (
    input  logic                            m00_axis_aclk,
    input  logic                            m00_axis_aresetn,
    input  logic                            frame_ready,
    output logic                            ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0]        ram_rd_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    ram_rd_data,
    lbm_axis_frame_streamer_if.master       m00_axis,
    output logic                            busy,
    output logic                            frame_done,
    output logic [15:0]                     frame_count
);
    localparam int FIFO_DEPTH = RAM_LATENCY + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(3 * FIFO_DEPTH);
    localparam int IW = ADDRESS_WIDTH + 1;
    localparam int DW = NUM_CH * DATA_WIDTH;
    localparam int EW = DW + 3;
    localparam logic [IW-1:0] DEPTH_I    = IW'(DEPTH);
    localparam logic [IW-1:0] LAST_I     = IW'(DEPTH - 1);
    localparam logic [IW-1:0] ROW_LAST_I = IW'(ROW_LEN - 1);
    localparam logic [CW-1:0] FD_C       = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_reg, state_next;
    logic                    accept, finish, issue, push, pop, head_final;
    logic                    rd_en_reg, busy_reg, done_reg;
    logic [ADDRESS_WIDTH-1:0] rd_addr_reg;
    logic [IW-1:0]           rd_idx_reg, row_reg;
    logic [2:0]              tag_reg, tag_next;
    logic                    vld_pipe_reg [RAM_LATENCY];
    logic [2:0]              tag_pipe_reg [RAM_LATENCY];
    logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]           head;
    logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           occ_reg, inflight, level;
    logic [15:0]             count_reg;

    assign head       = fifo_mem[rd_ptr_reg];
    assign head_final = head[DW+2];
    assign push       = vld_pipe_reg[RAM_LATENCY-1];
    assign pop        = (occ_reg != '0) && m00_axis.tready;

    // Everything already requested or buffered once this cycle's pop retires;
    // reads are throttled so this never exceeds the FIFO capacity.
    always_comb begin
        inflight = CW'(rd_en_reg);
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + CW'(vld_pipe_reg[i]);
        end
        level = occ_reg - CW'(pop) + inflight;
        issue = (state_reg == STREAM) && (rd_idx_reg < DEPTH_I) && (level < FD_C);
    end

    // Tags: {final beat of frame, tlast, tuser}
    always_comb begin
        tag_next    = '0;
        tag_next[0] = (rd_idx_reg == '0);
        tag_next[2] = (rd_idx_reg == LAST_I);
        tag_next[1] = tag_next[2] || ((TLAST_MODE == 1) && (row_reg == ROW_LAST_I));
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_ready) begin
                    accept     = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (pop && head_final) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_reg   <= IDLE;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            rd_idx_reg  <= '0;
            row_reg     <= '0;
            tag_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rd_en_reg <= issue;
            done_reg  <= finish;
            count_reg <= count_reg + 16'(finish);
            if (accept) begin
                rd_idx_reg <= '0;
                row_reg    <= '0;
                busy_reg   <= 1'b1;
            end else if (finish) begin
                busy_reg   <= 1'b0;
            end
            if (issue) begin
                rd_addr_reg <= rd_idx_reg[ADDRESS_WIDTH-1:0];
                rd_idx_reg  <= rd_idx_reg + 1'b1;
                row_reg     <= (row_reg == ROW_LAST_I) ? '0 : row_reg + 1'b1;
                tag_reg     <= tag_next;
            end
        end
    end

    // Tags ride alongside the RAM read latency so they meet their data at the FIFO.
    for (genvar gi = 0; gi < RAM_LATENCY; gi++) begin : g_pipe
        if (gi == 0) begin : g_first
            always_ff @(posedge m00_axis_aclk) begin
                if (!m00_axis_aresetn) begin
                    vld_pipe_reg[gi] <= 1'b0;
                    tag_pipe_reg[gi] <= '0;
                end else begin
                    vld_pipe_reg[gi] <= rd_en_reg;
                    tag_pipe_reg[gi] <= tag_reg;
                end
            end
        end else begin : g_rest
            always_ff @(posedge m00_axis_aclk) begin
                if (!m00_axis_aresetn) begin
                    vld_pipe_reg[gi] <= 1'b0;
                    tag_pipe_reg[gi] <= '0;
                end else begin
                    vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
                    tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
                end
            end
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {tag_pipe_reg[RAM_LATENCY-1], ram_rd_data};
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            occ_reg <= occ_reg + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge m00_axis_aclk) disable iff (!m00_axis_aresetn)
        !(push && !pop && (occ_reg == FD_C)));

    assign ram_rd_en       = rd_en_reg;
    assign ram_rd_addr     = rd_addr_reg;
    assign busy            = busy_reg;
    assign frame_done      = done_reg;
    assign frame_count     = count_reg;
    assign m00_axis.tvalid = (occ_reg != '0);
    assign m00_axis.tdata  = head[DW-1:0];
    assign m00_axis.tuser  = head[DW];
    assign m00_axis.tlast  = head[DW+1];
    assign m00_axis.tstrb  = '1;
endmodule

// File: tb/tb_lbm_axis_frame_streamer.sv
// Drives two streamer instances (latency 1 / per-frame tlast, latency 3 / per-row tlast)
// from one shared RAM image and compares every beat with an index-based reference.
module tb_lbm_axis_frame_streamer;
    localparam int DEPTH = 8;
    localparam int W     = 144;
    localparam int SW    = 18;

    logic clk;
    logic aresetn;
    logic frame_ready;
    logic tready;
    int   cyc = 0;
    int   n_err = 0;
    int   n_checks = 0;
    int   exp_fc = 0;

    logic [W-1:0] mem [DEPTH];

    lbm_axis_frame_streamer_if #(.DATA_WIDTH(16), .NUM_CH(9)) axa ();
    lbm_axis_frame_streamer_if #(.DATA_WIDTH(16), .NUM_CH(9)) axb ();
    assign axa.tready = tready;
    assign axb.tready = tready;

    logic          rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b;
    logic [11:0]   addr_a, addr_b;
    logic [W-1:0]  rdata_a, rdata_b;
    logic [15:0]   fc_a, fc_b;
    logic [W-1:0]  ramb_q [3];

    lbm_axis_frame_streamer #(.DATA_WIDTH(16), .NUM_CH(9), .DEPTH(DEPTH), .ADDRESS_WIDTH(12),
        .RAM_LATENCY(1), .TLAST_MODE(0), .ROW_LEN(50)) dut_a (
        .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .frame_ready(frame_ready),
        .ram_rd_en(rd_en_a), .ram_rd_addr(addr_a), .ram_rd_data(rdata_a),
        .m00_axis(axa), .busy(busy_a), .frame_done(done_a), .frame_count(fc_a));

    lbm_axis_frame_streamer #(.DATA_WIDTH(16), .NUM_CH(9), .DEPTH(DEPTH), .ADDRESS_WIDTH(12),
        .RAM_LATENCY(3), .TLAST_MODE(1), .ROW_LEN(3)) dut_b (
        .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .frame_ready(frame_ready),
        .ram_rd_en(rd_en_b), .ram_rd_addr(addr_b), .ram_rd_data(rdata_b),
        .m00_axis(axb), .busy(busy_b), .frame_done(done_b), .frame_count(fc_b));

    // Synchronous-read RAM models with 1 and 3 cycles of read latency
    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= mem[addr_a[2:0]];
        if (rd_en_b) ramb_q[0] <= mem[addr_b[2:0]];
        ramb_q[1] <= ramb_q[0];
        ramb_q[2] <= ramb_q[1];
    end
    assign rdata_b = ramb_q[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]    s_rden, s_tvalid, s_tlast, s_tuser, s_busy, s_done;
    logic [W-1:0]  s_tdata [2];
    logic [11:0]   s_addr  [2];
    logic [15:0]   s_fc    [2];
    logic [SW-1:0] s_tstrb [2];
    assign s_rden   = {rd_en_b, rd_en_a};
    assign s_tvalid = {axb.tvalid, axa.tvalid};
    assign s_tlast  = {axb.tlast, axa.tlast};
    assign s_tuser  = {axb.tuser, axa.tuser};
    assign s_busy   = {busy_b, busy_a};
    assign s_done   = {done_b, done_a};
    assign s_tdata[0] = axa.tdata;  assign s_tdata[1] = axb.tdata;
    assign s_addr[0]  = addr_a;     assign s_addr[1]  = addr_b;
    assign s_fc[0]    = fc_a;       assign s_fc[1]    = fc_b;
    assign s_tstrb[0] = axa.tstrb;  assign s_tstrb[1] = axb.tstrb;

    logic [W+1:0] beatq   [2][$];
    int           beatcyc [2][$];
    int           addrq   [2][$];
    int           rdcyc   [2][$];
    int           donecyc [2][$];
    int           first_tv [2];
    int           stab_err [2];
    logic         prev_stall [2];
    logic [W+1:0] prev_beat  [2];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        for (int d = 0; d < 2; d++) begin
            beatq[d].delete(); beatcyc[d].delete(); addrq[d].delete();
            rdcyc[d].delete(); donecyc[d].delete();
            first_tv[d] = -1; stab_err[d] = 0; prev_stall[d] = 1'b0; prev_beat[d] = '0;
        end
    endtask

    task automatic fill_mem();
        for (int j = 0; j < DEPTH; j++)
            for (int c = 0; c < 9; c++)
                mem[j][c*16 +: 16] = 16'($urandom);
    endtask

    // One cycle: choose tready for the coming edge, then record what each DUT shows.
    task automatic step(input logic tr);
        logic [W+1:0] b;
        @(negedge clk);
        tready = tr;
        for (int d = 0; d < 2; d++) begin
            b = {s_tdata[d], s_tlast[d], s_tuser[d]};
            if (s_rden[d]) begin
                addrq[d].push_back(int'(s_addr[d]));
                rdcyc[d].push_back(cyc);
            end
            if (s_tvalid[d] && first_tv[d] < 0) first_tv[d] = cyc;
            if (prev_stall[d] && (!s_tvalid[d] || b !== prev_beat[d])) stab_err[d]++;
            if (s_tvalid[d] && tr) begin
                beatq[d].push_back(b);
                beatcyc[d].push_back(cyc);
            end
            if (s_done[d]) donecyc[d].push_back(cyc);
            prev_stall[d] = s_tvalid[d] && !tr;
            prev_beat[d]  = b;
        end
    endtask

    // pat: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready
    task automatic run_until(input int ndone, input int pat, input bit hold);
        logic tr;
        for (int k = 0; k < 300; k++) begin
            if (donecyc[0].size() >= ndone && donecyc[1].size() >= ndone) break;
            tr = (pat == 0) ? 1'b1 : (pat == 1) ? ((k % 4 == 0) || (k % 4 == 3))
                                                : ($urandom_range(0, 3) != 0);
            step(tr);
            if (hold && donecyc[0].size() >= 1 && donecyc[1].size() >= 1 && s_busy == 2'b11)
                frame_ready = 1'b0;
        end
    endtask

    function automatic logic [W+1:0] exp_beat(input int d, input int j);
        logic l;
        l = (j == DEPTH - 1) || (d == 1 && ((j + 1) % 3 == 0));
        return {mem[j], l, (j == 0)};
    endfunction

    task automatic check_frame(input int d, input int f);
        logic [159:0] e, o;
        for (int j = 0; j < DEPTH; j++) begin
            int idx;
            idx = f * DEPTH + j;
            e = 160'(exp_beat(d, j));
            o = (idx < beatq[d].size()) ? 160'(beatq[d][idx]) : ~e;
            chk($sformatf("dut%0d frame%0d beat%0d", d, f, j), o, e);
            e = 160'(j);
            o = (idx < addrq[d].size()) ? 160'(addrq[d][idx]) : ~e;
            chk($sformatf("dut%0d frame%0d addr%0d", d, f, j), o, e);
        end
    endtask

    task automatic check_status(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d %s frame_count", d, tag), 160'(s_fc[d]), 160'(exp_fc));
            chk($sformatf("dut%0d %s busy", d, tag), 160'(s_busy[d]), 160'(0));
            chk($sformatf("dut%0d %s tvalid", d, tag), 160'(s_tvalid[d]), 160'(0));
        end
    endtask

    int start;

    initial begin
        aresetn = 1'b0; frame_ready = 1'b0; tready = 1'b0;
        fill_mem();
        clear_rec();
        repeat (3) step(1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset tvalid", d), 160'(s_tvalid[d]), 160'(0));
            chk($sformatf("dut%0d reset tlast", d), 160'(s_tlast[d]), 160'(0));
            chk($sformatf("dut%0d reset tuser", d), 160'(s_tuser[d]), 160'(0));
            chk($sformatf("dut%0d reset busy", d), 160'(s_busy[d]), 160'(0));
            chk($sformatf("dut%0d reset done", d), 160'(s_done[d]), 160'(0));
            chk($sformatf("dut%0d reset rd_en", d), 160'(s_rden[d]), 160'(0));
            chk($sformatf("dut%0d reset addr", d), 160'(s_addr[d]), 160'(0));
            chk($sformatf("dut%0d reset frame_count", d), 160'(s_fc[d]), 160'(0));
            chk($sformatf("dut%0d tstrb", d), 160'(s_tstrb[d]), 160'(18'h3ffff));
        end
        aresetn = 1'b1;
        step(1'b1);

        // Frame 1: full-rate, latency and timing
        clear_rec(); fill_mem();
        frame_ready = 1'b1; step(1'b1); start = cyc; frame_ready = 1'b0;
        chk("busy after accept", 160'(s_busy), 160'(2'b11));
        run_until(1, 0, 1'b0); step(1'b1); step(1'b1);
        exp_fc = 1;
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            chk($sformatf("dut%0d first rd_en cycle", d),
                160'(rdcyc[d].size() > 0 ? rdcyc[d][0] - start : -1), 160'(1));
            chk($sformatf("dut%0d read count", d), 160'(addrq[d].size()), 160'(DEPTH));
            chk($sformatf("dut%0d first tvalid cycle", d), 160'(first_tv[d] - start), 160'(lat + 2));
            chk($sformatf("dut%0d beat count", d), 160'(beatq[d].size()), 160'(DEPTH));
            chk($sformatf("dut%0d no bubbles", d),
                160'(beatcyc[d].size() == DEPTH ? beatcyc[d][DEPTH-1] - beatcyc[d][0] : -1),
                160'(DEPTH - 1));
            chk($sformatf("dut%0d frame_done cycle", d),
                160'(donecyc[d].size() > 0 ? donecyc[d][0] - start : -1), 160'(lat + DEPTH + 2));
            check_frame(d, 0);
        end
        check_status("frame1");

        // Frames 2 and 3: backpressure, fixed toggle then random
        for (int pat = 1; pat <= 2; pat++) begin
            clear_rec(); fill_mem();
            frame_ready = 1'b1; step(1'b1); frame_ready = 1'b0;
            run_until(1, pat, 1'b0); step(1'b1); step(1'b1);
            exp_fc++;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d pat%0d beat count", d, pat), 160'(beatq[d].size()), 160'(DEPTH));
                chk($sformatf("dut%0d pat%0d stall stability", d, pat), 160'(stab_err[d]), 160'(0));
                check_frame(d, 0);
            end
            check_status($sformatf("pat%0d", pat));
        end

        // frame_ready held: back-to-back frames, no queued third frame
        clear_rec(); fill_mem();
        frame_ready = 1'b1; step(1'b1);
        run_until(2, 0, 1'b1);
        frame_ready = 1'b0;
        repeat (20) step(1'b1);
        exp_fc += 2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d held done count", d), 160'(donecyc[d].size()), 160'(2));
            chk($sformatf("dut%0d held beat count", d), 160'(beatq[d].size()), 160'(2 * DEPTH));
            chk($sformatf("dut%0d restart rd_en cycle", d),
                160'((rdcyc[d].size() > DEPTH && donecyc[d].size() > 0)
                     ? rdcyc[d][DEPTH] - donecyc[d][0] : -1), 160'(2));
            check_frame(d, 0);
            check_frame(d, 1);
        end
        check_status("held");

        // Reset while beat 4 of dut0 is presented
        clear_rec(); fill_mem();
        frame_ready = 1'b1; step(1'b1); frame_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1);
            if (beatq[0].size() == 5) break;
        end
        chk("beat4 reached before reset", 160'(beatq[0].size()), 160'(5));
        aresetn = 1'b0;
        step(1'b1);
        aresetn = 1'b1;
        exp_fc = 0;
        check_status("midreset");

        clear_rec(); fill_mem();
        frame_ready = 1'b1; step(1'b1); frame_ready = 1'b0;
        run_until(1, 0, 1'b0); step(1'b1); step(1'b1);
        exp_fc = 1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d post-reset beat count", d), 160'(beatq[d].size()), 160'(DEPTH));
            check_frame(d, 0);
        end
        check_status("post-reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
